// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_stage_skid                                               |
// | Purpose  : valid/ready pipeline register with 2-entry skid, flush and    |
// |            saturating back-pressure counter                              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int DATA_W = 256,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_head_data;
  logic [DATA_W-1:0] w_head_data_nxt;
  logic [CTRL_W-1:0] r_head_ctrl;
  logic [CTRL_W-1:0] w_head_ctrl_nxt;
  logic [DATA_W-1:0] r_skid_data;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic              r_in_ready;
  logic              w_in_ready_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  w_stall_cnt_nxt;

  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_head_data_nxt = r_head_data;
    w_head_ctrl_nxt = r_head_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_stall_cnt_nxt = r_stall_cnt;

    if (flush) begin
      // Stored control is zeroed so a squashed entry can never re-surface as a write.
      w_state_nxt     = EMPTY;
      w_head_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
            w_state_nxt     = ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end else if (w_push) begin
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
            w_state_nxt     = FULL;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_head_data_nxt = r_skid_data;
            w_head_ctrl_nxt = r_skid_ctrl;
            w_state_nxt     = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end

    // Registered ready depends only on next occupancy, never on out_ready directly.
    w_in_ready_nxt = (w_state_nxt != FULL);

    if (w_out_valid && !out_ready && !flush && (r_stall_cnt != c_cnt_max)) begin
      w_stall_cnt_nxt = r_stall_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_head_data <= '0;
      r_head_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_in_ready  <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_ctrl <= w_head_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_head_data;
  assign out_ctrl  = r_head_ctrl & {CTRL_W{w_out_valid}};
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Self-checking bench for pipe_stage_skid: directed scenarios plus random
// traffic, scored against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];
  int   m_cnt;
  bit   fresh;
  bit   started;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/model: compare DUT against model, then advance model to the next edge.
  always @(negedge clk) begin
    bit   m_valid;
    bit   m_ready;
    ent_t e;
    if (started) begin
      m_valid = (q.size() > 0);
      m_ready = (q.size() < 2);
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
      end else begin
        chk("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
        if (fresh) chk("out_data_reset", 64'(out_data), 64'd0);
      end
    end
    if (reset) begin
      q.delete();
      m_cnt   = 0;
      fresh   = 1'b1;
      started = 1'b1;
    end else if (started) begin
      m_valid = (q.size() > 0);
      m_ready = (q.size() < 2);
      if (m_valid && !out_ready && !flush && m_cnt < CNT_MAX) m_cnt++;
      if (m_valid && out_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else if (in_valid && m_ready) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
        fresh = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry until accepted, bounded.
  task automatic push_one(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit ok;
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    for (int k = 0; k < 20; k++) begin
      rdy = in_ready;
      cyc();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("push_accept_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    started   = 1'b0;
    fresh     = 1'b1;
    m_cnt     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;

    // 1: single entry
    out_ready = 1'b1;
    push_one(32'h11, 8'h03);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h11);
    cyc();
    chk("t1_bubble_valid", 64'(out_valid), 64'd0);
    chk("t1_bubble_ctrl", 64'(out_ctrl), 64'd0);

    // 2: streaming
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_ctrl  = 8'($urandom);
      cyc();
      chk("t2_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("t2_stall", 64'(stall_cnt), 64'd0);

    // 3: back-pressure
    out_ready = 1'b0;
    push_one(32'hA, 8'h01);
    push_one(32'hB, 8'h02);
    in_valid = 1'b1;
    in_data  = 32'hC;
    in_ctrl  = 8'h04;
    repeat (3) cyc();
    chk("t3_occ", 64'(occupancy), 64'd2);
    chk("t3_ready", 64'(in_ready), 64'd0);
    chk("t3_head", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    push_one(32'hC, 8'h04);
    repeat (4) cyc();

    // 4: flush while full with concurrent push
    out_ready = 1'b0;
    push_one(32'h40, 8'hF0);
    push_one(32'h41, 8'hF1);
    in_valid = 1'b1;
    in_data  = 32'hDD;
    in_ctrl  = 8'hFF;
    flush    = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_occ", 64'(occupancy), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_ctrl", 64'(out_ctrl), 64'd0);
    chk("t4_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();

    // 5: saturation
    out_ready = 1'b0;
    push_one(32'hE, 8'h05);
    repeat (20) cyc();
    chk("t5_sat", 64'(stall_cnt), 64'(CNT_MAX));
    repeat (3) cyc();
    chk("t5_hold", 64'(stall_cnt), 64'(CNT_MAX));

    // 6: reset mid-transfer
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    push_one(32'hF, 8'h06);
    push_one(32'h10, 8'h07);
    for (int k = 0; k < 20 && stall_cnt != 4'd7; k++) cyc();
    chk("t6_pre_occ", 64'(occupancy), 64'd2);
    chk("t6_pre_stall", 64'(stall_cnt), 64'd7);
    reset = 1'b1;
    cyc();
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_data", 64'(out_data), 64'd0);
    chk("t6_ctrl", 64'(out_ctrl), 64'd0);
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_stall", 64'(stall_cnt), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    push_one(32'h11, 8'h03);
    chk("t6_push_valid", 64'(out_valid), 64'd1);
    chk("t6_push_data", 64'(out_data), 64'h11);
    chk("t6_push_ctrl", 64'(out_ctrl), 64'h03);
    cyc();
    chk("t6_after_valid", 64'(out_valid), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 5);
      reset     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
